wb_arbiter: RTL and testbench

- Write-back arbiter that drives the register file's single write port (write enable, write address, write data) from two result producers:
  - a single-cycle execute channel (EX), which has priority and no backpressure;
  - a long-latency memory/multiply channel (MEM), which uses a valid/ready handshake and is buffered in a small FIFO.
- Sits between the execute/memory stages and the register file.
- Also supplies forwarding data for two read addresses, so decode sees writes the register file has not yet committed.

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges a priority single-cycle EX channel and a buffered
// long-latency MEM channel onto the register file's single write port, and
// forwards not-yet-committed write data to two decode read ports.
module wb_arbiter #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned addr_width = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [addr_width-1:0] ex_rd,
    input  logic [BITS-1:0]       ex_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [addr_width-1:0] mem_rd,
    input  logic [BITS-1:0]       mem_data,
    output logic                  rf_wen,
    output logic [addr_width-1:0] rf_aw,
    output logic [BITS-1:0]       rf_d,
    input  logic [addr_width-1:0] ra1,
    input  logic [addr_width-1:0] ra2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [BITS-1:0]       fwd1_data,
    output logic [BITS-1:0]       fwd2_data
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    // MEM buffer storage
    logic [addr_width-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [addr_width-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [BITS-1:0]       fifo_data_q [FIFO_DEPTH];
    logic [BITS-1:0]       fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_live_q, fifo_live_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    // Output stage register
    logic                  rf_wen_q, rf_wen_d;
    logic [addr_width-1:0] rf_aw_q, rf_aw_d;
    logic [BITS-1:0]       rf_d_q, rf_d_d;

    logic ex_fire, push, pop, full;

    assign full      = (count_q == CntW'(FIFO_DEPTH));
    // Occupancy-only ready, forced low while reset is held.
    assign mem_ready = reset && !full;

    assign rf_wen = rf_wen_q;
    assign rf_aw  = rf_aw_q;
    assign rf_d   = rf_d_q;

    // Source selection, EX-over-MEM kill, and FIFO next-state
    always_comb begin
        ex_fire     = ex_valid && (ex_rd != '0);
        push        = mem_valid && mem_ready;
        pop         = !ex_fire && (count_q != '0);
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        fifo_live_d = fifo_live_q;
        rf_wen_d    = 1'b0;
        rf_aw_d     = rf_aw_q;
        rf_d_d      = rf_d_q;

        // EX is younger than everything buffered: older writes to the same rd die.
        if (ex_fire) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (fifo_rd_q[i] == ex_rd) begin
                    fifo_live_d[i] = 1'b0;
                end
            end
        end

        // Push never targets a valid slot since it only happens when not full.
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = mem_rd;
            fifo_data_d[wr_ptr_q] = mem_data;
            fifo_live_d[wr_ptr_q] = (mem_rd != '0) && !(ex_fire && (mem_rd == ex_rd));
        end

        if (ex_fire) begin
            rf_wen_d = 1'b1;
            rf_aw_d  = ex_rd;
            rf_d_d   = ex_data;
        end else if (pop) begin
            rf_wen_d = fifo_live_q[rd_ptr_q];
            rf_aw_d  = fifo_rd_q[rd_ptr_q];
            rf_d_d   = fifo_data_q[rd_ptr_q];
        end

        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    // State registers; reset discards every buffered result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_live_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rf_wen_q    <= 1'b0;
            rf_aw_q     <= '0;
            rf_d_q      <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            fifo_live_q <= fifo_live_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rf_wen_q    <= rf_wen_d;
            rf_aw_q     <= rf_aw_d;
            rf_d_q      <= rf_d_d;
        end
    end

    logic [1:0][addr_width-1:0] ra_vec;
    logic [1:0]                 hit;
    logic [1:0][BITS-1:0]       hit_data;
    logic [PtrW-1:0]            idx;

    assign ra_vec = {ra2, ra1};

    // Forwarding lookup: stage register lowest priority, then FIFO oldest to
    // youngest so the youngest live match overrides.
    always_comb begin
        hit      = '0;
        hit_data = '0;
        idx      = '0;
        for (int p = 0; p < 2; p++) begin
            if (rf_wen_q && (rf_aw_q == ra_vec[p])) begin
                hit[p]      = 1'b1;
                hit_data[p] = rf_d_q;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                idx = rd_ptr_q + PtrW'(k);
                if ((CntW'(k) < count_q) && fifo_live_q[idx] && (fifo_rd_q[idx] == ra_vec[p])) begin
                    hit[p]      = 1'b1;
                    hit_data[p] = fifo_data_q[idx];
                end
            end
            if (ra_vec[p] == '0) begin
                hit[p]      = 1'b0;
                hit_data[p] = '0;
            end
        end
    end

    assign fwd1_hit  = hit[0];
    assign fwd2_hit  = hit[1];
    assign fwd1_data = hit_data[0];
    assign fwd2_data = hit_data[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_wb_arbiter;

    localparam int Depth = 2;

    logic        clk, reset;
    logic        ex_valid, mem_valid, mem_ready;
    logic [4:0]  ex_rd, mem_rd, rf_aw, ra1, ra2;
    logic [31:0] ex_data, mem_data, rf_d, fwd1_data, fwd2_data;
    logic        rf_wen, fwd1_hit, fwd2_hit;

    wb_arbiter #(.BITS(32), .addr_width(5), .FIFO_DEPTH(Depth)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_rd     (ex_rd),
        .ex_data   (ex_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rf_wen    (rf_wen),
        .rf_aw     (rf_aw),
        .rf_d      (rf_d),
        .ra1       (ra1),
        .ra2       (ra2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Register-file commit log seen from the DUT write port.
    logic [31:0] shadow [32];
    logic [4:0]  wr_log [1024];
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (rf_wen) begin
            shadow[rf_aw] <= rf_d;
            if (wr_cnt < 1024) wr_log[wr_cnt] <= rf_aw;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model: pending MEM results in arrival order, plus the write port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } ent_t;

    ent_t        m_q[$];
    logic        m_wen;
    logic [4:0]  m_aw;
    logic [31:0] m_d;

    task automatic model_reset();
        m_q.delete();
        m_wen = 1'b0;
        m_aw  = '0;
        m_d   = '0;
    endtask

    function automatic logic [32:0] m_fwd(input logic [4:0] ra);
        if (ra == 0) return '0;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].live && m_q[i].rd == ra) return {1'b1, m_q[i].data};
        if (m_wen && m_aw == ra) return {1'b1, m_d};
        return '0;
    endfunction

    task automatic model_step(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              output logic acc);
        logic fire;
        logic popped;
        ent_t head;
        ent_t e;
        fire   = ev && (erd != 0);
        acc    = mv && (m_q.size() < Depth);
        popped = 1'b0;
        if (fire)
            foreach (m_q[i]) if (m_q[i].rd == erd) m_q[i].live = 1'b0;
        if (!fire && m_q.size() > 0) begin
            head   = m_q.pop_front();
            popped = 1'b1;
        end
        if (acc) begin
            e.rd   = mrd;
            e.data = md;
            e.live = (mrd != 0) && !(fire && mrd == erd);
            m_q.push_back(e);
        end
        if (fire) begin
            m_wen = 1'b1; m_aw = erd; m_d = ed;
        end else if (popped) begin
            m_wen = head.live; m_aw = head.rd; m_d = head.data;
        end else begin
            m_wen = 1'b0;
        end
    endtask

    // One clock: apply inputs after the falling edge, compare, then advance the model.
    task automatic drive_cycle(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic [4:0] a1, input logic [4:0] a2, output logic acc);
        logic [32:0] f1, f2;
        @(negedge clk);
        ex_valid = ev; ex_rd = erd; ex_data = ed;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        ra1 = a1; ra2 = a2;
        #1;
        f1 = m_fwd(a1);
        f2 = m_fwd(a2);
        check("rf_wen", rf_wen, m_wen);
        check("rf_aw", rf_aw, m_aw);
        check("rf_d", rf_d, m_d);
        check("mem_ready", mem_ready, m_q.size() < Depth);
        check("fwd1_hit", fwd1_hit, f1[32]);
        check("fwd1_data", fwd1_data, f1[31:0]);
        check("fwd2_hit", fwd2_hit, f2[32]);
        check("fwd2_data", fwd2_data, f2[31:0]);
        @(posedge clk);
        model_step(ev, erd, ed, mv, mrd, md, acc);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        logic        acc, pend, saw_not_ready;
        logic [4:0]  prd;
        logic [31:0] pdata;
        int          base, idx3;
        int          exp3[7];
        logic [4:0]  mrd3[3];
        logic [31:0] mdat3[3];

        reset = 1'b0;
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        ra1 = 0; ra2 = 0;
        model_reset();

        // Reset held for three cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ra1 = 5'(c * 3 + 1);
            ra2 = 5'(c * 5 + 2);
            #1;
            check("rst_wen", rf_wen, 0);
            check("rst_aw", rf_aw, 0);
            check("rst_d", rf_d, 0);
            check("rst_ready", mem_ready, 0);
            check("rst_fwd1", fwd1_hit, 0);
            check("rst_fwd2", fwd2_hit, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_rst", mem_ready, 1);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            check("empty_fwd1", fwd1_hit, 0);
            check("empty_fwd2", fwd2_hit, 0);
        end

        // EX write and forward from the stage register
        drive_cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, acc);
        #1;
        check("ex_wen", rf_wen, 1);
        check("ex_aw", rf_aw, 5);
        check("ex_d", rf_d, 32'hDEADBEEF);
        check("ex_fwd_hit", fwd1_hit, 1);
        check("ex_fwd_data", fwd1_data, 32'hDEADBEEF);
        drive_cycle(1, 0, 32'h12345678, 0, 0, 0, 5, 0, acc);
        #1;
        check("ex_x0_wen", rf_wen, 0);
        idle(2);

        // MEM buffering behind busy EX, with backpressure
        exp3 = '{1, 2, 3, 4, 7, 8, 9};
        mrd3 = '{7, 8, 9};
        mdat3 = '{32'h11, 32'h22, 32'h33};
        base = wr_cnt;
        idx3 = 0;
        saw_not_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(c < 4, 5'(c + 1), 32'(c + 100), idx3 < 3,
                        idx3 < 3 ? mrd3[idx3] : 5'd0, idx3 < 3 ? mdat3[idx3] : 32'd0,
                        7, 9, acc);
            if (acc) idx3++;
            #1;
            if (!mem_ready) saw_not_ready = 1'b1;
        end
        check("mem_all_accepted", idx3, 3);
        check("mem_ready_dropped", saw_not_ready, 1);
        check("mem_write_count", wr_cnt - base, 7);
        for (int i = 0; i < 7; i++) check("mem_write_order", wr_log[base + i], exp3[i]);
        check("x9_value", shadow[9], 32'h33);

        // Kill: buffered rd=3 superseded by a later EX write to rd=3
        drive_cycle(0, 0, 0, 1, 3, 32'hAAAA, 3, 0, acc);
        drive_cycle(1, 3, 32'hBBBB, 0, 0, 0, 3, 0, acc);
        #1;
        check("kill_ex_aw", rf_aw, 3);
        check("kill_fwd", fwd1_data, 32'hBBBB);
        drive_cycle(0, 0, 0, 0, 0, 0, 3, 0, acc);
        #1;
        check("kill_pop_wen", rf_wen, 0);
        idle(2);
        check("kill_x3", shadow[3], 32'hBBBB);
        // Same-cycle variant
        drive_cycle(1, 3, 32'hCCCC, 1, 3, 32'hDDDD, 3, 0, acc);
        idle(3);
        check("kill_same_x3", shadow[3], 32'hCCCC);

        // Forwarding priority: youngest FIFO entry, then FIFO over stage register
        drive_cycle(0, 0, 0, 1, 4, 32'h1, 0, 4, acc);
        drive_cycle(1, 9, 32'h99, 1, 4, 32'h2, 0, 4, acc);
        #1;
        check("fwd_youngest", fwd2_data, 32'h2);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 4, acc);
        #1;
        check("fwd_stage_aw", rf_aw, 4);
        check("fwd_stage_d", rf_d, 32'h1);
        check("fwd_fifo_over_stage", fwd2_data, 32'h2);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        #1;
        check("fwd_x0_hit", fwd2_hit, 0);
        idle(2);

        // Reset mid-operation with two results buffered
        drive_cycle(1, 10, 32'hA0, 1, 4, 32'h55, 0, 0, acc);
        drive_cycle(1, 11, 32'hB0, 1, 6, 32'h66, 0, 0, acc);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_wen", rf_wen, 0);
        check("midrst_ready", mem_ready, 0);
        base = wr_cnt;
        ex_valid = 0; mem_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(6);
        check("midrst_no_writes", wr_cnt - base, 0);

        // Randomized traffic against the model
        pend = 1'b0;
        prd = '0;
        pdata = '0;
        for (int c = 0; c < 500; c++) begin
            if (!pend && $urandom_range(0, 99) < 60) begin
                pend = 1'b1;
                prd = 5'($urandom_range(0, 7));
                pdata = $urandom;
            end
            drive_cycle($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
                        pend, prd, pdata,
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
            if (acc) pend = 1'b0;
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
